// File: rtl/can_pkg.sv
// can_pkg: shared states, error codes, field widths and CRC-15 step for the CAN receive framer
package can_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_WAIT_IDLE
  } can_state_e;
  localparam logic [2:0] ERR_STUFF = 3'b001;
  localparam logic [2:0] ERR_FORM = 3'b010;
  localparam logic [2:0] ERR_CRC = 3'b100;
  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam int ID_W = 11;
  localparam int DLC_W = 4;
  localparam int CRC_W = 15;
  localparam int EOF_W = 7;
  function automatic logic [14:0] crc15_step(input logic [14:0] c, input logic b);
    return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? CAN_CRC15_POLY : 15'h0);
  endfunction
endpackage

// File: rtl/can_crc15.sv
// can_crc15: serial CAN CRC-15; clear restarts from 0 and may coincide with the first bit
// ports: clk, rst, clear, bit_en (advance by bit_in), crc (running remainder)
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [14:0] crc
);
  logic [14:0] w_base;
  assign w_base = clear ? '0 : crc;
  always_ff @(posedge clk)
    if (rst) crc <= '0;
    else if (clear || bit_en) crc <= bit_en ? crc15_step(w_base, bit_in) : '0;
endmodule

// File: rtl/can_rx_frame.sv
// can_rx_frame: CAN 2.0A receive framer with destuffing, form/stuff checks and ACK request
// ports: clk, rst, rxd_synced/sampling_point/can_bus_idle in; frame_valid + id/rtr/dlc/data,
//        frame_error + error_code, ack_drive out
// CAN_RX_CRC_CHECK_EN: when defined, the received CRC-15 is checked at the CRC delimiter
module can_rx_frame
  import can_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd_synced,
  input  logic                        sampling_point,
  input  logic                        can_bus_idle,
  output logic                        frame_valid,
  output logic [ID_W-1:0]             frame_id,
  output logic                        frame_rtr,
  output logic [DLC_W-1:0]            frame_dlc,
  output logic [MAX_DATA_BYTES*8-1:0] frame_data,
  output logic                        frame_error,
  output logic [2:0]                  error_code,
  output logic                        ack_drive
);
  localparam logic [5:0] TOP = 6'(MAX_DATA_BYTES * 8 - 1);
  can_state_e r_state, w_next;
  logic [5:0] r_cnt, w_len_m1;
  logic [2:0] r_run, w_err;
  logic r_last, r_rtr;
  logic [ID_W-1:0] r_id;
  logic [DLC_W-1:0] r_dlc, w_dlc_full, w_n;
  logic [MAX_DATA_BYTES*8-1:0] r_data;
  logic w_destuff, w_stuff, w_take, w_sof, w_last, w_done, w_crc_bad;
  assign w_destuff = r_state inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC};
  // after five equal samples the next sample inside the stuffed region is a stuff bit
  assign w_stuff = w_destuff && r_run == 3'd5;
  assign w_sof = sampling_point && r_state == S_IDLE && !rxd_synced;
  assign w_take = sampling_point && !can_bus_idle && !w_stuff && r_state != S_IDLE && r_state != S_WAIT_IDLE;
  assign w_dlc_full = {r_dlc[DLC_W-2:0], rxd_synced};
  assign w_n = (r_dlc > 4'(MAX_DATA_BYTES)) ? 4'(MAX_DATA_BYTES) : r_dlc;
  assign w_len_m1 = (r_state == S_ID)   ? 6'(ID_W - 1) :
                    (r_state == S_DLC)  ? 6'(DLC_W - 1) :
                    (r_state == S_DATA) ? 6'({w_n, 3'b000} - 7'd1) :
                    (r_state == S_CRC)  ? 6'(CRC_W - 1) :
                    (r_state == S_EOF)  ? 6'(EOF_W - 1) : 6'd0;
  assign w_last = r_cnt == w_len_m1;
`ifdef CAN_RX_CRC_CHECK_EN
  logic [14:0] w_crc, r_crc_rx;
  logic w_crc_en;
  assign w_crc_en = w_sof || (w_take && r_state inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA});
  can_crc15 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (w_sof),
    .bit_en(w_crc_en),
    .bit_in(rxd_synced),
    .crc   (w_crc)
  );
  always_ff @(posedge clk)
    if (rst) r_crc_rx <= '0;
    else if (w_take && r_state == S_CRC) r_crc_rx <= {r_crc_rx[13:0], rxd_synced};
  assign w_crc_bad = r_crc_rx != w_crc;
`else
  assign w_crc_bad = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_err = '0;
    w_done = 1'b0;
    if (can_bus_idle && r_state != S_IDLE) w_next = S_IDLE;
    else if (sampling_point && w_stuff) w_err = (rxd_synced == r_last) ? ERR_STUFF : '0;
    else if (sampling_point)
      case (r_state)
        S_IDLE:    w_next = rxd_synced ? S_IDLE : S_ID;
        S_ID:      w_next = w_last ? S_RTR : S_ID;
        S_RTR:     w_next = S_IDE;
        S_IDE:     w_next = rxd_synced ? S_WAIT_IDLE : S_R0;
        S_R0:      w_next = S_DLC;
        S_DLC:     w_next = !w_last ? S_DLC : (r_rtr || w_dlc_full == '0) ? S_CRC : S_DATA;
        S_DATA:    w_next = w_last ? S_CRC : S_DATA;
        S_CRC:     w_next = w_last ? S_CRC_DEL : S_CRC;
        S_CRC_DEL: begin
          w_err = !rxd_synced ? ERR_FORM : w_crc_bad ? ERR_CRC : '0;
          w_next = S_ACK;
        end
        S_ACK:     w_next = S_ACK_DEL;
        S_ACK_DEL: begin
          w_err = rxd_synced ? '0 : ERR_FORM;
          w_next = S_EOF;
        end
        S_EOF:     begin
          w_err = rxd_synced ? '0 : ERR_FORM;
          w_done = rxd_synced && w_last;
          w_next = w_done ? S_IDLE : S_EOF;
        end
        default:   w_next = r_state;
      endcase
    if (|w_err) w_next = S_WAIT_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_run <= '0;
      r_last <= 1'b0;
      r_id <= '0;
      r_rtr <= 1'b0;
      r_dlc <= '0;
      r_data <= '0;
      frame_valid <= 1'b0;
      frame_id <= '0;
      frame_rtr <= 1'b0;
      frame_dlc <= '0;
      frame_data <= '0;
      frame_error <= 1'b0;
      error_code <= '0;
      ack_drive <= 1'b0;
    end else begin
      r_state <= w_next;
      frame_valid <= w_done;
      frame_error <= |w_err;
      if (|w_err) error_code <= w_err;
      // the ACK state spans exactly CRC_DEL sample to ACK sample
      ack_drive <= w_next == S_ACK;
      if (w_sof) begin
        r_run <= 3'd1;
        r_last <= 1'b0;
        r_cnt <= '0;
        r_data <= '0;
      end else begin
        if (sampling_point && !can_bus_idle && w_destuff) begin
          r_run <= (w_stuff || rxd_synced != r_last) ? 3'd1 : r_run + 3'd1;
          r_last <= rxd_synced;
        end
        if (w_take) begin
          r_cnt <= w_last ? '0 : r_cnt + 6'd1;
          case (r_state)
            S_ID:    r_id <= {r_id[ID_W-2:0], rxd_synced};
            S_RTR:   r_rtr <= rxd_synced;
            S_DLC:   r_dlc <= w_dlc_full;
            S_DATA:  r_data[TOP-r_cnt] <= rxd_synced;
            default: ;
          endcase
        end
      end
      if (w_done) begin
        frame_id <= r_id;
        frame_rtr <= r_rtr;
        frame_dlc <= r_dlc;
        frame_data <= r_data;
      end
    end
endmodule

// File: tb/tb_can_rx_frame.sv
// tb_can_rx_frame: randomized and directed frames checked against a bit-list reference model
module tb_can_rx_frame;
  logic clk = 1'b0, rst = 1'b1, rxd_synced = 1'b1, sampling_point = 1'b0, can_bus_idle = 1'b0;
  logic frame_valid, frame_rtr, frame_error, ack_drive;
  logic [10:0] frame_id;
  logic [3:0] frame_dlc;
  logic [63:0] frame_data;
  logic [2:0] error_code;
  can_rx_frame #(.MAX_DATA_BYTES(8)) dut (
    .clk(clk), .rst(rst), .rxd_synced(rxd_synced), .sampling_point(sampling_point),
    .can_bus_idle(can_bus_idle), .frame_valid(frame_valid), .frame_id(frame_id),
    .frame_rtr(frame_rtr), .frame_dlc(frame_dlc), .frame_data(frame_data),
    .frame_error(frame_error), .error_code(error_code), .ack_drive(ack_drive)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, vcnt = 0, ecnt = 0, both = 0, v0, e0, ack_idx, eof_start;
  bit ack_any, ack_slot;
  bit q_bits[$];
  logic [63:0] exp_data;
  always @(negedge clk) begin
    if (frame_valid) vcnt++;
    if (frame_error) ecnt++;
    if (frame_valid && frame_error) both++;
    if (ack_drive) ack_any = 1'b1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // reference: plain field list, CRC by polynomial long division, then bit stuffing
  task automatic build(input logic [10:0] id, input bit rtr, input bit ide, input logic [3:0] dlc,
                       input logic [63:0] data, input bit flip_crc);
    bit m[$];
    bit r[$];
    logic [15:0] g;
    logic [14:0] crc;
    int n, run;
    bit last;
    g = 16'hC599;
    m.push_back(1'b0);
    for (int i = 10; i >= 0; i--) m.push_back(id[i]);
    m.push_back(rtr);
    m.push_back(ide);
    m.push_back(1'b0);
    for (int i = 3; i >= 0; i--) m.push_back(dlc[i]);
    n = rtr ? 0 : (dlc > 8 ? 8 : int'(dlc));
    exp_data = '0;
    for (int i = 0; i < 8 * n; i++) begin
      m.push_back(data[63-i]);
      exp_data[63-i] = data[63-i];
    end
    r = m;
    for (int i = 0; i < 15; i++) r.push_back(1'b0);
    for (int i = 0; i < m.size(); i++)
      if (r[i]) for (int j = 0; j < 16; j++) r[i+j] = r[i+j] ^ g[15-j];
    for (int j = 0; j < 15; j++) crc[14-j] = r[m.size()+j];
    if (flip_crc) crc[7] = ~crc[7];
    for (int j = 14; j >= 0; j--) m.push_back(crc[j]);
    q_bits = {};
    run = 0;
    last = 1'b0;
    for (int i = 0; i < m.size(); i++) begin
      q_bits.push_back(m[i]);
      run = (i == 0 || m[i] != last) ? 1 : run + 1;
      last = m[i];
      if (run == 5 && i != m.size() - 1) begin
        q_bits.push_back(!last);
        last = !last;
        run = 1;
      end
    end
    ack_idx = q_bits.size() + 1;
    repeat (3) q_bits.push_back(1'b1);
    eof_start = q_bits.size();
    repeat (7) q_bits.push_back(1'b1);
  endtask
  task automatic send(input int upto);
    v0 = vcnt;
    e0 = ecnt;
    ack_any = 1'b0;
    ack_slot = 1'b0;
    for (int k = 0; k < q_bits.size(); k++) begin
      if (upto >= 0 && k == upto) break;
      @(negedge clk);
      if (k == ack_idx) ack_slot = ack_drive;
      rxd_synced = q_bits[k];
      sampling_point = 1'b1;
      @(negedge clk);
      sampling_point = 1'b0;
      rxd_synced = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask
  task automatic bus_idle();
    @(negedge clk);
    can_bus_idle = 1'b1;
    @(negedge clk);
    can_bus_idle = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic expect_ok(input string tag, input logic [10:0] id, input bit rtr, input logic [3:0] dlc);
    chk({tag, "_valid"}, 64'(vcnt - v0), 64'd1);
    chk({tag, "_err"}, 64'(ecnt - e0), 64'd0);
    chk({tag, "_id"}, 64'(frame_id), 64'(id));
    chk({tag, "_rtr"}, 64'(frame_rtr), 64'(rtr));
    chk({tag, "_dlc"}, 64'(frame_dlc), 64'(dlc));
    chk({tag, "_data"}, frame_data, exp_data);
    chk({tag, "_ack"}, 64'(ack_slot), 64'd1);
  endtask
  task automatic expect_err(input string tag, input logic [2:0] code);
    chk({tag, "_valid"}, 64'(vcnt - v0), 64'd0);
    chk({tag, "_err"}, 64'(ecnt - e0), 64'd1);
    chk({tag, "_code"}, 64'(error_code), 64'(code));
  endtask
  task automatic expect_none(input string tag);
    chk({tag, "_valid"}, 64'(vcnt - v0), 64'd0);
    chk({tag, "_err"}, 64'(ecnt - e0), 64'd0);
  endtask
  initial begin
    logic [10:0] id;
    logic [3:0] dlc;
    logic [63:0] dat;
    bit rtr;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", 64'({frame_valid, frame_error, error_code, ack_drive, frame_rtr, frame_dlc, frame_id}), 64'd0);
    chk("reset_data", frame_data, 64'd0);
    build(11'h123, 0, 0, 4'd2, 64'hA55A_0000_0000_0000, 0);
    send(-1);
    expect_ok("basic", 11'h123, 0, 4'd2);
    chk("basic_data_lit", frame_data, 64'hA55A_0000_0000_0000);
    build(11'h7F0, 1, 0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    send(-1);
    expect_ok("remote", 11'h7F0, 1, 4'd4);
    build(11'h000, 0, 0, 4'd1, 64'h1100_0000_0000_0000, 0);
    q_bits[5] = 1'b0;
    send(-1);
    expect_err("stuff", 3'b001);
    build(11'h055, 0, 0, 4'd1, 64'h3C00_0000_0000_0000, 0);
    send(-1);
    expect_none("wait_idle");
    bus_idle();
    build(11'h2A1, 0, 0, 4'd3, 64'h1234_5600_0000_0000, 1);
    send(-1);
`ifdef CAN_RX_CRC_CHECK_EN
    expect_err("crc", 3'b100);
    chk("crc_no_ack", 64'(ack_any), 64'd0);
    bus_idle();
`else
    chk("crc_off_valid", 64'(vcnt - v0), 64'd1);
    chk("crc_off_err", 64'(ecnt - e0), 64'd0);
`endif
    build(11'h3AB, 0, 0, 4'd15, 64'h0102_0304_0506_0708, 0);
    send(-1);
    expect_ok("dlc15", 11'h3AB, 0, 4'd15);
    build(11'h321, 0, 0, 4'd1, 64'hEE00_0000_0000_0000, 0);
    q_bits[eof_start+2] = 1'b0;
    send(-1);
    expect_err("eof_form", 3'b010);
    chk("eof_hold", frame_data, 64'h0102_0304_0506_0708);
    bus_idle();
    build(11'h400, 0, 1, 4'd2, 64'h9900_0000_0000_0000, 0);
    send(-1);
    expect_none("ide");
    bus_idle();
    build(11'h0AA, 0, 0, 4'd8, 64'hDEAD_BEEF_CAFE_F00D, 0);
    send(60);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_none("rst_mid");
    chk("rst_mid_out", 64'({frame_dlc, frame_id, error_code}), 64'd0);
    build(11'h055, 0, 0, 4'd1, 64'h3C00_0000_0000_0000, 0);
    send(-1);
    expect_ok("after_rst", 11'h055, 0, 4'd1);
    build(11'h1F0, 0, 0, 4'd8, 64'h0011_2233_4455_6677, 0);
    send(50);
    bus_idle();
    expect_none("abort");
    for (int t = 0; t < 8; t++) begin
      id = 11'($urandom_range(0, 2047));
      rtr = $urandom_range(0, 3) == 0;
      dlc = 4'($urandom_range(0, 15));
      dat = {$urandom, $urandom};
      build(id, rtr, 0, dlc, dat, 0);
      send(-1);
      expect_ok($sformatf("rand%0d", t), id, rtr, dlc);
    end
    chk("never_both", 64'(both), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
